// File: rtl/cache_store_if.sv
// Lookup and fill bus between the cache controller/RAM path and cache_store.
interface cache_store_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] cache_address;
  logic [DATA_W-1:0] cache_write_data;
  logic              cache_read;
  logic              cache_write;
  logic              fill_valid;
  logic [DATA_W-1:0] fill_data;
  logic              cache_hit;
  logic              cache_miss;
  logic              dirty_evicted;
  logic [ADDR_W-1:0] evicted_address;
  logic [DATA_W-1:0] evicted_data;
  logic [DATA_W-1:0] cache_read_data;
  logic              fill_done;
  logic              pending;

  modport master (
    output cache_address, cache_write_data, cache_read, cache_write,
           fill_valid, fill_data,
    input  cache_hit, cache_miss, dirty_evicted, evicted_address,
           evicted_data, cache_read_data, fill_done, pending
  );

  modport slave (
    input  cache_address, cache_write_data, cache_read, cache_write,
           fill_valid, fill_data,
    output cache_hit, cache_miss, dirty_evicted, evicted_address,
           evicted_data, cache_read_data, fill_done, pending
  );
endinterface

// File: rtl/cache_store.sv
// Direct-mapped data/tag array: registered lookup, dirty-victim report on miss,
// and a single outstanding miss completed (with write merge) by a line fill.
module cache_store #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int INDEX_W = 6
) (
  input logic           clk,
  input logic           rst_n,
  cache_store_if.slave  bus
);
  // state        | meaning
  // ST_IDLE      | no miss outstanding, lookups evaluated
  // ST_WAIT_FILL | miss outstanding, waiting for fill_valid
  typedef enum logic {ST_IDLE, ST_WAIT_FILL} state_t;

  localparam int TAG_W = ADDR_W - INDEX_W - 3;
  localparam int LINES = 1 << INDEX_W;

  state_t              r_state;
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [DATA_W-1:0]   r_data [LINES];

  logic                r_req_valid;
  logic                r_req_wr;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [DATA_W-1:0]   r_req_wdata;

  logic                r_pend_wr;
  logic [ADDR_W-1:0]   r_pend_addr;
  logic [DATA_W-1:0]   r_pend_wdata;

  logic                r_hit;
  logic                r_miss;
  logic                r_dirty_ev;
  logic [ADDR_W-1:0]   r_ev_addr;
  logic [DATA_W-1:0]   r_ev_data;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_fill_done;

  logic                w_accept;
  logic [INDEX_W-1:0]  w_req_idx;
  logic [TAG_W-1:0]    w_req_tag;
  logic [INDEX_W-1:0]  w_pend_idx;
  logic [TAG_W-1:0]    w_pend_tag;
  logic                w_hit;
  logic                w_pending;

  assign w_pending  = (r_state == ST_WAIT_FILL);
  assign w_accept   = (bus.cache_read | bus.cache_write) & ~w_pending & ~bus.fill_valid;
  assign w_req_idx  = r_req_addr[INDEX_W+2:3];
  assign w_req_tag  = r_req_addr[ADDR_W-1:INDEX_W+3];
  assign w_pend_idx = r_pend_addr[INDEX_W+2:3];
  assign w_pend_tag = r_pend_addr[ADDR_W-1:INDEX_W+3];
  assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_req_valid  <= 1'b0;
      r_req_wr     <= 1'b0;
      r_req_addr   <= '0;
      r_req_wdata  <= '0;
      r_pend_wr    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_dirty_ev   <= 1'b0;
      r_ev_addr    <= '0;
      r_ev_data    <= '0;
      r_rdata      <= '0;
      r_fill_done  <= 1'b0;
    end else begin
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_dirty_ev  <= 1'b0;
      r_fill_done <= 1'b0;

      r_req_valid <= w_accept;
      if (w_accept) begin
        r_req_wr    <= bus.cache_write;
        r_req_addr  <= bus.cache_address;
        r_req_wdata <= bus.cache_write_data;
      end

      case (r_state)
        ST_IDLE: begin
          // A request captured in the same cycle a miss was raised is dropped,
          // since evaluation only happens from ST_IDLE.
          if (r_req_valid) begin
            if (w_hit) begin
              r_hit <= 1'b1;
              if (r_req_wr) begin
                r_data[w_req_idx]  <= r_req_wdata;
                r_dirty[w_req_idx] <= 1'b1;
                r_rdata            <= r_req_wdata;
              end else begin
                r_rdata <= r_data[w_req_idx];
              end
            end else begin
              r_miss       <= 1'b1;
              r_state      <= ST_WAIT_FILL;
              r_pend_wr    <= r_req_wr;
              r_pend_addr  <= r_req_addr;
              r_pend_wdata <= r_req_wdata;
              if (r_valid[w_req_idx] && r_dirty[w_req_idx]) begin
                r_dirty_ev <= 1'b1;
                r_ev_addr  <= {r_tag[w_req_idx], w_req_idx, 3'b000};
                r_ev_data  <= r_data[w_req_idx];
              end
            end
          end
        end
        ST_WAIT_FILL: begin
          if (bus.fill_valid) begin
            r_tag[w_pend_idx]   <= w_pend_tag;
            r_valid[w_pend_idx] <= 1'b1;
            r_dirty[w_pend_idx] <= r_pend_wr;
            if (r_pend_wr) begin
              r_data[w_pend_idx] <= r_pend_wdata;
              r_rdata            <= r_pend_wdata;
            end else begin
              r_data[w_pend_idx] <= bus.fill_data;
              r_rdata            <= bus.fill_data;
            end
            r_fill_done <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cache_hit       = r_hit;
  assign bus.cache_miss      = r_miss;
  assign bus.dirty_evicted   = r_dirty_ev;
  assign bus.evicted_address = r_ev_addr;
  assign bus.evicted_data    = r_ev_data;
  assign bus.cache_read_data = r_rdata;
  assign bus.fill_done       = r_fill_done;
  assign bus.pending         = w_pending;
endmodule

// File: tb/tb_cache_store.sv
// Directed vectors for cache_store with hand-computed expected results.
module tb_cache_store;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miscmp;

  cache_store_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  cache_store #(.ADDR_W(32), .DATA_W(64), .INDEX_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe one lookup; returns after the result edge, at a negedge.
  task automatic lookup(input logic wr, input logic [31:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    bus.cache_address    = addr;
    bus.cache_write_data = wdata;
    bus.cache_read       = ~wr;
    bus.cache_write      = wr;
    @(negedge clk);
    bus.cache_read  = 1'b0;
    bus.cache_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill(input logic [63:0] data);
    @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.fill_data  = data;
    @(negedge clk);
    bus.fill_valid = 1'b0;
  endtask

  task automatic check_miss(input string tag, input logic dev);
    check_vec({tag, "_miss"}, 64'(bus.cache_miss), 64'd1);
    check_vec({tag, "_hit"},  64'(bus.cache_hit),  64'd0);
    check_vec({tag, "_dev"},  64'(bus.dirty_evicted), 64'(dev));
    check_vec({tag, "_pend"}, 64'(bus.pending), 64'd1);
  endtask

  task automatic check_hit(input string tag, input logic [63:0] data);
    check_vec({tag, "_hit"},  64'(bus.cache_hit),  64'd1);
    check_vec({tag, "_miss"}, 64'(bus.cache_miss), 64'd0);
    check_vec({tag, "_data"}, bus.cache_read_data, data);
  endtask

  task automatic check_fill(input string tag, input logic [63:0] data);
    check_vec({tag, "_done"}, 64'(bus.fill_done), 64'd1);
    check_vec({tag, "_data"}, bus.cache_read_data, data);
    check_vec({tag, "_pend"}, 64'(bus.pending), 64'd0);
  endtask

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    rst_n = 1'b0;
    bus.cache_address    = '0;
    bus.cache_write_data = '0;
    bus.cache_read       = 1'b0;
    bus.cache_write      = 1'b0;
    bus.fill_valid       = 1'b0;
    bus.fill_data        = '0;
    repeat (3) @(negedge clk);
    check_vec("rst_hit",  64'(bus.cache_hit), 64'd0);
    check_vec("rst_miss", 64'(bus.cache_miss), 64'd0);
    check_vec("rst_pend", 64'(bus.pending), 64'd0);
    check_vec("rst_done", 64'(bus.fill_done), 64'd0);
    check_vec("rst_rd",   bus.cache_read_data, 64'd0);
    rst_n = 1'b1;

    // read miss on empty line, fill, reread
    lookup(1'b0, 32'h0000_0040, 64'd0);
    check_miss("rm1", 1'b0);
    fill(64'hDEAD_BEEF_0000_0001);
    check_fill("f1", 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    check_vec("f1_pulse", 64'(bus.fill_done), 64'd0);
    lookup(1'b0, 32'h0000_0040, 64'd0);
    check_hit("rh1", 64'hDEAD_BEEF_0000_0001);
    check_vec("rh1_pulse_len", 64'(bus.cache_hit), 64'd1);
    @(negedge clk);
    check_vec("rh1_pulse_end", 64'(bus.cache_hit), 64'd0);

    // write hit, then read back
    lookup(1'b1, 32'h0000_0040, 64'h1111);
    check_hit("wh", 64'h1111);
    lookup(1'b0, 32'h0000_0045, 64'd0);
    check_hit("rh2", 64'h1111);

    // dirty eviction: same index 8, tag 1
    lookup(1'b0, 32'h0000_0240, 64'd0);
    check_miss("ev", 1'b1);
    check_vec("ev_addr", 64'(bus.evicted_address), 64'h40);
    check_vec("ev_data", bus.evicted_data, 64'h1111);
    check_vec("ev_rd_held", bus.cache_read_data, 64'h1111);
    fill(64'h2222);
    check_fill("f2", 64'h2222);
    lookup(1'b0, 32'h0000_0240, 64'd0);
    check_hit("rh3", 64'h2222);

    // write miss on empty index 1 (tag 8), fill data discarded for write data
    lookup(1'b1, 32'h0000_1008, 64'hABCD);
    check_miss("wm", 1'b0);
    fill(64'h5555);
    check_fill("f3", 64'hABCD);
    lookup(1'b0, 32'h0000_1008, 64'd0);
    check_hit("rh4", 64'hABCD);
    lookup(1'b0, 32'h0000_0008, 64'd0);
    check_miss("ev2", 1'b1);
    check_vec("ev2_addr", 64'(bus.evicted_address), 64'h1008);
    check_vec("ev2_data", bus.evicted_data, 64'hABCD);

    // lookup while pending is ignored
    lookup(1'b0, 32'h0000_0240, 64'd0);
    check_vec("ign_hit",  64'(bus.cache_hit), 64'd0);
    check_vec("ign_miss", 64'(bus.cache_miss), 64'd0);
    check_vec("ign_pend", 64'(bus.pending), 64'd1);
    fill(64'h7777);
    check_fill("f4", 64'h7777);

    // stray fill with nothing pending
    fill(64'h9999);
    check_vec("stray_done", 64'(bus.fill_done), 64'd0);
    check_vec("stray_rd",   bus.cache_read_data, 64'h7777);
    check_vec("stray_pend", 64'(bus.pending), 64'd0);
    lookup(1'b0, 32'h0000_0008, 64'd0);
    check_hit("rh5", 64'h7777);

    // reset in the middle of a miss
    lookup(1'b0, 32'h0000_3000, 64'd0);
    check_miss("rm2", 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_vec("mrst_pend", 64'(bus.pending), 64'd0);
    check_vec("mrst_rd",   bus.cache_read_data, 64'd0);
    check_vec("mrst_miss", 64'(bus.cache_miss), 64'd0);
    rst_n = 1'b1;
    lookup(1'b0, 32'h0000_0240, 64'd0);
    check_miss("post_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule

// File: doc/cache_store.md
# cache_store

Direct-mapped data/tag array sitting directly downstream of the cache controller. It answers the controller's lookup strobes with registered hit/miss, read data and dirty-victim information, and accepts line fills from the RAM path. A miss is remembered as pending until its fill arrives; a pending write is merged into the fill. Read-miss data is returned on fill completion.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 64, line width (one word per line)
- INDEX_W, 6, index bits (2^INDEX_W lines); offset is fixed at 3 bits, tag = ADDR_W-INDEX_W-3 bits

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cache_address  in  ADDR_W  lookup address from controller
- cache_write_data  in  DATA_W  write data for lookup
- cache_read  in  1  read lookup strobe
- cache_write  in  1  write lookup strobe (wins if both high)
- fill_valid  in  1  one-cycle fill strobe from RAM path
- fill_data  in  DATA_W  line returned by RAM
- cache_hit  out  1  one-cycle pulse, lookup hit
- cache_miss  out  1  one-cycle pulse, lookup miss
- dirty_evicted  out  1  qualifies cache_miss: victim valid and dirty
- evicted_address  out  ADDR_W  {victim_tag, index, 3'b000}, valid with dirty_evicted
- evicted_data  out  DATA_W  victim line, valid with dirty_evicted
- cache_read_data  out  DATA_W  hit/fill data, held until next update
- fill_done  out  1  one-cycle pulse, fill installed
- pending  out  1  miss outstanding, fill awaited

## Operation
- Storage: per line valid, dirty, tag, data. Address split: offset [2:0] ignored, index [INDEX_W+2:3], tag [ADDR_W-1:INDEX_W+3].
- Reset (rst_n=0 at edge): all valid and dirty bits cleared, pending=0, every output 0. Tag/data arrays not cleared. Reset mid-miss discards the pending request.
- Lookup accepted when (cache_read|cache_write) and pending=0 and fill_valid=0. Address, op, write data captured.
- Hit (valid and tag match): read -> cache_read_data = line data; write -> line data = write data, dirty=1, cache_read_data = write data. cache_hit pulses.
- Miss: cache_miss pulses; if victim valid and dirty, dirty_evicted=1 with evicted_address/evicted_data for that cycle. Array unchanged. pending=1; op, address, write data held.
- Fill: fill_valid with pending=1 -> line at held index gets tag, valid=1; read miss: data=fill_data, dirty=0, cache_read_data=fill_data; write miss: data=held write data, dirty=1, cache_read_data=held write data. fill_done pulses, pending=0.
- fill_valid with pending=0: ignored, no state change.
- Lookup strobes while pending=1 or in the same cycle as fill_valid: ignored (not queued). Controller does not issue them.
- Victim data for write-back is taken from evicted_* at the miss pulse; the controller must latch them.

## Timing
- Lookup latency 1: strobe at edge N, hit/miss/dirty_evicted/read data valid after edge N+1 for exactly one cycle (matches controller CHECK_CACHE state).
- Back-to-back lookups to the same line: second sees first's write (array written at edge N+1, read for next lookup at N+2).
- fill_done and installed data visible one cycle after the fill_valid edge; a lookup issued the cycle after fill_done sees the new line.
- cache_hit and cache_miss are never high together; dirty_evicted is high only when cache_miss is high.
- pending rises with cache_miss, falls with fill_done.

## Test plan
- Reset then read 0x0000_0040 -> cache_miss=1, dirty_evicted=0, pending=1; fill 0xDEAD_BEEF_0000_0001 -> fill_done, cache_read_data=that value; reread -> cache_hit, same data.
- Write hit: after fill above, write 0x0000_0040 data 0x1111 -> cache_hit; read -> 0x1111.
- Dirty eviction: same index, address 0x0000_0240 (different tag) read -> cache_miss, dirty_evicted=1, evicted_address=0x0000_0040, evicted_data=0x1111.
- Write miss: write 0x0000_1008 data 0xABCD on an empty line, fill 0x5555 -> line holds 0xABCD, dirty; later conflicting miss reports dirty_evicted.
- Ignored events: lookup while pending=1 -> no hit/miss pulse; stray fill_valid with pending=0 -> no fill_done, array unchanged.
- Reset mid-miss: rst_n low while pending=1 -> pending=0, all outputs 0, prior lines invalid (reread misses).
